// File: rtl/saradc_11b_dig_conv_sched.sv
// Conversion scheduler for the 11-bit SAR ADC core: powers the converter up,
// round-robin arbitrates NREQ requesters, launches conversions and returns results.
module saradc_11b_dig_conv_sched #(
  parameter int NREQ    = 4,
  parameter int CHNR_W  = 5,
  parameter int RES_W   = 11,
  parameter int TMO_CYC = 255
) (
  input  logic                     clk_i,
  input  logic                     res_n_i,
  input  logic                     enable_i,
  input  logic [NREQ-1:0]          req_i,
  input  logic [NREQ*CHNR_W-1:0]   req_chnr_i,
  output logic [NREQ-1:0]          ack_o,
  output logic [RES_W-1:0]         res_data_o,
  output logic                     res_err_o,
  output logic                     mod_enable_o,
  input  logic                     mod_ready_i,
  output logic                     start_adc_o,
  output logic [CHNR_W-1:0]        chnr_o,
  input  logic                     busy_i,
  input  logic                     eoc_i,
  input  logic [RES_W-1:0]         result_i,
  output logic [1:0]               state_o
);

  localparam int IDX_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_PWRUP = 2'd1,
    S_ARB   = 2'd2,
    S_CONV  = 2'd3
  } state_t;

  state_t           state, state_next;
  logic [IDX_W-1:0] ptr, winner, pick, ptr_after;
  logic             pick_valid;
  logic [7:0]       cnt, cnt_inc;
  logic             grant, done, done_err;
  logic             unused_busy;

  // busy is informational only; sequencing relies on eoc and the timeout
  assign unused_busy = busy_i;
  assign state_o     = state;
  assign cnt_inc     = cnt + 8'd1;
  assign ptr_after   = (winner == IDX_W'(NREQ - 1)) ? '0 : winner + IDX_W'(1);

  always_comb begin
    int idx;
    idx        = 0;
    pick       = ptr;
    pick_valid = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      idx = (int'(ptr) + i) % NREQ;
      if (!pick_valid && req_i[idx]) begin
        pick       = IDX_W'(idx);
        pick_valid = 1'b1;
      end
    end
  end

  // In CONV, eoc beats a ready loss, which beats the timeout
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    case (state)
      S_OFF: begin
        if (enable_i) state_next = S_PWRUP;
      end
      S_PWRUP: begin
        if (!enable_i)        state_next = S_OFF;
        else if (mod_ready_i) state_next = S_ARB;
      end
      S_ARB: begin
        if (!enable_i)         state_next = S_OFF;
        else if (!mod_ready_i) state_next = S_PWRUP;
        else if (pick_valid) begin
          grant      = 1'b1;
          state_next = S_CONV;
        end
      end
      S_CONV: begin
        if (eoc_i) begin
          done       = 1'b1;
          state_next = S_ARB;
        end else if (!mod_ready_i) begin
          done       = 1'b1;
          done_err   = 1'b1;
          state_next = S_PWRUP;
        end else if (cnt_inc == 8'(TMO_CYC)) begin
          done       = 1'b1;
          done_err   = 1'b1;
          state_next = S_ARB;
        end
      end
      default: state_next = S_OFF;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) state <= S_OFF;
    else          state <= state_next;
  end

  always_ff @(posedge clk_i) begin
    if (!res_n_i) begin
      mod_enable_o <= 1'b0;
      start_adc_o  <= 1'b0;
      chnr_o       <= '0;
      ack_o        <= '0;
      res_data_o   <= '0;
      res_err_o    <= 1'b0;
      ptr          <= '0;
      winner       <= '0;
      cnt          <= '0;
    end else begin
      mod_enable_o <= (state_next != S_OFF);
      start_adc_o  <= grant;
      ack_o        <= '0;
      if (grant) begin
        winner <= pick;
        chnr_o <= req_chnr_i[pick*CHNR_W +: CHNR_W];
        cnt    <= '0;
      end else if (state == S_CONV) begin
        cnt <= cnt_inc;
      end
      if (done) begin
        ack_o[winner] <= 1'b1;
        res_data_o    <= done_err ? '0 : result_i;
        res_err_o     <= done_err;
        ptr           <= ptr_after;
      end
    end
  end

endmodule

// File: doc/saradc_11b_dig_conv_sched.md
# saradc_11b_dig_conv_sched

Conversion scheduler for the 11-bit SAR ADC digital core. It shares the single converter among NREQ requesters with round-robin arbitration. It powers the module up via mod_enable/mod_ready, issues one-cycle start_adc pulses with the granted channel number, and waits for eoc with a timeout. It then returns the result to the winning requester. It sits on the master side of the mackerel sync stage, driving its mod_enable/start_adc/chnr inputs and consuming its mod_ready/busy/eoc/result outputs.

## Interface
- NREQ, 4, number of requesters (2..8)
- CHNR_W, 5, channel-number width
- RES_W, 11, result width
- TMO_CYC, 255, max CONV cycles before timeout (1..255, 8-bit counter)
- clk_i  in  1  clock; single clock domain
- res_n_i  in  1  reset, synchronous, active-low
- enable_i  in  1  scheduler enable; low powers the ADC down once idle
- req_i  in  NREQ  per-requester conversion request (level)
- req_chnr_i  in  NREQ*CHNR_W  channel for requester k at bits [k*CHNR_W +: CHNR_W]
- ack_o  out  NREQ  one-hot, one-cycle completion pulse to the granted requester
- res_data_o  out  RES_W  result, valid while any ack_o bit is high, held afterwards
- res_err_o  out  1  qualifies ack_o: conversion aborted (timeout or mod_ready loss)
- mod_enable_o  out  1  to ADC: module enable
- mod_ready_i  in  1  from ADC: module powered and ready
- start_adc_o  out  1  to ADC: start pulse, exactly one cycle
- chnr_o  out  CHNR_W  to ADC: channel of the current conversion
- busy_i  in  1  from ADC: conversion in progress (status only, not used for sequencing)
- eoc_i  in  1  from ADC: end-of-conversion pulse
- result_i  in  RES_W  from ADC: result, valid when eoc_i is high
- state_o  out  2  FSM state for debug (OFF=0, PWRUP=1, ARB=2, CONV=3)

## Operation
- Reset (res_n_i low at posedge): state OFF; all outputs 0; round-robin pointer 0; timeout counter 0.
- OFF: mod_enable_o=0. If enable_i=1, go to PWRUP.
- PWRUP: mod_enable_o=1. If mod_ready_i=1, go to ARB. If enable_i=0, go to OFF.
- ARB: mod_enable_o=1.
  - If enable_i=0, go to OFF.
  - Else if mod_ready_i=0, go to PWRUP.
  - Else if any req_i bit is set: select the first set bit searching upward from pointer, wrapping modulo NREQ. Register winner index and chnr_o from req_chnr_i of the winner. Assert start_adc_o for the next cycle, clear the timeout counter, go to CONV.
- CONV: start_adc_o is high only in the first CONV cycle. chnr_o is held constant for the whole state. The counter increments every cycle.
  - eoc_i=1: res_data_o<=result_i, res_err_o<=0, ack_o[winner]<=1, pointer<=winner+1 (mod NREQ), go to ARB.
  - Counter reaches TMO_CYC without eoc_i: res_data_o<=0, res_err_o<=1, ack pulse and pointer update as for eoc, go to ARB.
  - mod_ready_i=0 (and no eoc_i that cycle): same as timeout, go to PWRUP.
- Priority in CONV: eoc_i > mod_ready_i loss > timeout.
- eoc_i outside CONV is ignored.
- enable_i=0 during CONV does not abort: the conversion completes (or times out), then ARB moves to OFF.
- Requesters must deassert req_i in the cycle after ack_o. A request still high is treated as a new request. Round-robin guarantees each of NREQ continuous requesters is served once per NREQ conversions.
- req_chnr_i changes after grant do not affect chnr_o.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- req_i sampled high in ARB → start_adc_o=1 on the next cycle (1-cycle latency). chnr_o is valid in the same cycle as start_adc_o.
- eoc_i high at edge N → ack_o, res_data_o, res_err_o valid in cycle N+1. State is ARB in N+1. The earliest next start_adc_o is at N+2. start_adc_o is therefore low for at least 2 cycles between pulses, as required by the downstream rising-edge detector.
- Timeout: ack_o with res_err_o=1 is asserted in the cycle after TMO_CYC CONV cycles have elapsed without eoc_i.
- enable_i rise in OFF → mod_enable_o=1 after 1 cycle. mod_ready_i rise in PWRUP → ARB after 1 cycle.
- Synchronous reset mid-CONV: all outputs are 0 at the next cycle. No ack is issued for the aborted conversion.

## Test plan
- Single request: enable_i=1, mod_ready_i rises after 5 cycles, then req_i=0001 with chnr 7 → one start_adc_o pulse with chnr_o=7. eoc_i with result 0x5A3 → ack_o=0001, res_data_o=0x5A3, res_err_o=0.
- Round-robin: req_i=1111 held, acking each after eoc → grant order 0,1,2,3,0. Set req_i=1010 with pointer=0 → grant 1, then 3.
- Timeout: TMO_CYC=10, no eoc_i → ack_o with res_err_o=1 and res_data_o=0 exactly 10 CONV cycles after start_adc_o. The next request is granted normally.
- Power loss: mod_ready_i drops 3 cycles into CONV → err ack, state PWRUP, no start_adc_o until mod_ready_i returns.
- Disable mid-conversion: enable_i=0 during CONV → eoc_i still acked normally, then ARB→OFF, mod_enable_o=0. A pending req_i is not granted.
- Sync reset during CONV → all outputs 0, state_o=0. A stray eoc_i afterwards produces no ack.
